// File: rtl/tuner_sweep_peak_search.sv
// rtl/tuner_sweep_peak_search.sv - ring tuning DAC sweep with threshold/hysteresis peak table
module tuner_sweep_peak_search #(
    parameter int DAC_WIDTH     = 8,
    parameter int ADC_WIDTH     = 8,
    parameter int NUM_TARGET    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_trig_val,
    output logic                            o_trig_rdy,
    input  logic [DAC_WIDTH-1:0]            i_cfg_start,
    input  logic [DAC_WIDTH-1:0]            i_cfg_end,
    input  logic [DAC_WIDTH-1:0]            i_cfg_stride,
    input  logic                            i_cfg_dir,
    input  logic                            i_cfg_mode,
    input  logic [ADC_WIDTH-1:0]            i_cfg_thresh,
    input  logic [ADC_WIDTH-1:0]            i_cfg_hyst,
    output logic                            o_dac_val,
    output logic [DAC_WIDTH-1:0]            o_dac_code,
    input  logic                            i_dac_rdy,
    output logic                            o_pwr_rdy,
    input  logic                            i_pwr_val,
    input  logic [ADC_WIDTH-1:0]            i_pwr_data,
    output logic                            o_peaks_val,
    input  logic                            i_peaks_rdy,
    output logic [DAC_WIDTH*NUM_TARGET-1:0] o_peak_codes,
    output logic [ADC_WIDTH*NUM_TARGET-1:0] o_peak_pwrs,
    output logic [$clog2(NUM_TARGET+1)-1:0] o_peak_cnt,
    output logic                            o_overflow,
    output logic                            o_busy
);

    localparam int CW = $clog2(NUM_TARGET + 1);
    localparam int IW = (NUM_TARGET > 1) ? $clog2(NUM_TARGET) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_FULL    = CW'(NUM_TARGET);

    typedef enum logic [2:0] {
        S_IDLE, S_SET, S_SETTLE, S_SAMPLE, S_EVAL, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [DAC_WIDTH-1:0]   code_q, end_q, stride_q;
    logic                   dir_q, mode_q;
    logic [ADC_WIDTH-1:0]   thresh_q, hyst_q, samp_q;
    logic [SW-1:0]          settle_q;
    logic [ADC_WIDTH-1:0]   cand_pwr_q;
    logic [DAC_WIDTH-1:0]   cand_code_q;
    logic                   cand_armed_q;
    logic [DAC_WIDTH-1:0]   tab_code_q [NUM_TARGET];
    logic [ADC_WIDTH-1:0]   tab_pwr_q  [NUM_TARGET];
    logic [CW-1:0]          cnt_q;
    logic                   ovf_q;

    logic [DAC_WIDTH:0]     next_ext;
    logic                   sweep_last;
    logic                   cand_rise, commit, full;
    logic [IW-1:0]          min_idx;
    logic [IW-1:0]          wr_idx;

    // Next sweep point with carry/borrow so wrap past either end terminates the sweep
    always_comb begin
        next_ext   = '0;
        sweep_last = 1'b0;
        if (dir_q) begin
            next_ext   = {1'b0, code_q} - {1'b0, stride_q};
            sweep_last = next_ext[DAC_WIDTH] || (next_ext[DAC_WIDTH-1:0] < end_q);
        end else begin
            next_ext   = {1'b0, code_q} + {1'b0, stride_q};
            sweep_last = next_ext[DAC_WIDTH] || (next_ext[DAC_WIDTH-1:0] > end_q);
        end
    end

    // Peak decision terms and the weakest table slot (lowest index wins ties)
    always_comb begin
        cand_rise = samp_q > cand_pwr_q;
        commit    = cand_armed_q && (cand_pwr_q >= thresh_q) &&
                    (({1'b0, samp_q} + {1'b0, hyst_q}) <= {1'b0, cand_pwr_q});
        full      = (cnt_q == CNT_FULL);
        wr_idx    = cnt_q[IW-1:0];
        min_idx   = '0;
        for (int i = 1; i < NUM_TARGET; i++) begin
            if (tab_pwr_q[i] < tab_pwr_q[min_idx]) begin
                min_idx = IW'(i);
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (i_trig_val) state_d = S_SET;
            S_SET:    if (i_dac_rdy) state_d = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
            S_SETTLE: if (settle_q == SETTLE_LAST) state_d = S_SAMPLE;
            S_SAMPLE: if (i_pwr_val) state_d = S_EVAL;
            S_EVAL:   state_d = sweep_last ? S_DONE : S_SET;
            S_DONE:   if (i_peaks_rdy) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Config latch, sweep code, settle timer, candidate tracking and peak table
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            code_q       <= '0;
            end_q        <= '0;
            stride_q     <= '0;
            dir_q        <= 1'b0;
            mode_q       <= 1'b0;
            thresh_q     <= '0;
            hyst_q       <= '0;
            samp_q       <= '0;
            settle_q     <= '0;
            cand_pwr_q   <= '0;
            cand_code_q  <= '0;
            cand_armed_q <= 1'b0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            for (int i = 0; i < NUM_TARGET; i++) begin
                tab_code_q[i] <= '0;
                tab_pwr_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_trig_val) begin
                        code_q       <= i_cfg_start;
                        end_q        <= i_cfg_end;
                        stride_q     <= (i_cfg_stride == '0) ? DAC_WIDTH'(1) : i_cfg_stride;
                        dir_q        <= i_cfg_dir;
                        mode_q       <= i_cfg_mode;
                        thresh_q     <= i_cfg_thresh;
                        hyst_q       <= i_cfg_hyst;
                        cand_pwr_q   <= '0;
                        cand_code_q  <= '0;
                        cand_armed_q <= 1'b0;
                        cnt_q        <= '0;
                        ovf_q        <= 1'b0;
                        for (int i = 0; i < NUM_TARGET; i++) begin
                            tab_code_q[i] <= '0;
                            tab_pwr_q[i]  <= '0;
                        end
                    end
                end
                S_SET:    settle_q <= '0;
                S_SETTLE: settle_q <= settle_q + SW'(1);
                S_SAMPLE: if (i_pwr_val) samp_q <= i_pwr_data;
                S_EVAL: begin
                    if (cand_rise) begin
                        cand_pwr_q   <= samp_q;
                        cand_code_q  <= code_q;
                        cand_armed_q <= 1'b1;
                    end else if (commit) begin
                        cand_pwr_q   <= samp_q;
                        cand_code_q  <= code_q;
                        cand_armed_q <= 1'b0;
                        if (!full) begin
                            tab_code_q[wr_idx] <= cand_code_q;
                            tab_pwr_q[wr_idx]  <= cand_pwr_q;
                            cnt_q              <= cnt_q + CW'(1);
                        end else begin
                            ovf_q <= 1'b1;
                            if (mode_q && (cand_pwr_q > tab_pwr_q[min_idx])) begin
                                tab_code_q[min_idx] <= cand_code_q;
                                tab_pwr_q[min_idx]  <= cand_pwr_q;
                            end
                        end
                    end
                    if (!sweep_last) begin
                        code_q <= next_ext[DAC_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from state and result registers
    always_comb begin
        o_trig_rdy   = (state_q == S_IDLE);
        o_busy       = (state_q != S_IDLE);
        o_dac_val    = (state_q == S_SET);
        o_dac_code   = code_q;
        o_pwr_rdy    = (state_q == S_SAMPLE);
        o_peaks_val  = (state_q == S_DONE);
        o_peak_cnt   = cnt_q;
        o_overflow   = ovf_q;
        o_peak_codes = '0;
        o_peak_pwrs  = '0;
        for (int i = 0; i < NUM_TARGET; i++) begin
            o_peak_codes[i*DAC_WIDTH +: DAC_WIDTH] = tab_code_q[i];
            o_peak_pwrs[i*ADC_WIDTH +: ADC_WIDTH]  = tab_pwr_q[i];
        end
    end

endmodule
